// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates and reconfigures an attached receiver, buffers
// received characters in a show-ahead FIFO, and flags overflow and idle timeout.
module uart_rx_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cfg_wr,
    input  logic [1:0]                 cfg_parity_in,
    input  logic [1:0]                 cfg_stop_bits_in,
    input  logic [15:0]                cfg_clk_div_in,
    input  logic [15:0]                cfg_timeout,
    input  logic                       uart_rx,
    input  logic [WIDTH-1:0]           rx_dout,
    input  logic                       rx_valid,
    input  logic                       parity_err,
    output logic                       rx_rst,
    output logic [1:0]                 cfg_parity,
    output logic [1:0]                 cfg_stop_bits,
    output logic [15:0]                cfg_clk_div,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_perr,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic                       cfg_pending,
    output logic                       timeout
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam int unsigned EW       = WIDTH + 1;
    localparam logic [15:0] DIV_RST  = 16'd53;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_RUN    = 2'd1,
        S_RECONF = 2'd2
    } state_t;

    state_t           state;
    logic             rc_cnt;
    logic             sync1;
    logic             line_s;
    logic [1:0]       pend_parity;
    logic [1:0]       pend_stop;
    logic [15:0]      pend_div;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [15:0]      idle_cnt;

    logic             full_c;
    logic             pop_c;
    logic             push_req_c;
    logic             push_c;
    logic             drop_c;
    logic             reconf_go_c;
    logic             idle_clr_c;
    logic [LW-1:0]    level_nxt_c;

    assign full_c      = (level == LW'(DEPTH));
    assign pop_c       = m_valid & m_ready;
    assign push_req_c  = rx_valid & (state == S_RUN);
    assign push_c      = push_req_c & (~full_c | pop_c);
    assign drop_c      = push_req_c & full_c & ~pop_c;
    assign reconf_go_c = en & cfg_pending &
                         ((state == S_OFF) | ((state == S_RUN) & line_s));
    assign idle_clr_c  = push_c | pop_c | (level == '0);

    // Show-ahead head of the FIFO
    assign m_data = mem[rd_ptr][WIDTH-1:0];
    assign m_perr = mem[rd_ptr][WIDTH];

    always_comb begin
        level_nxt_c = level;
        if (push_c && !pop_c)
            level_nxt_c = level + LW'(1);
        else if (pop_c && !push_c)
            level_nxt_c = level - LW'(1);
    end

    // Line idle detector; the line idles high, so the synchronizer resets to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            line_s <= 1'b1;
        end else begin
            sync1  <= uart_rx;
            line_s <= sync1;
        end
    end

    // Receiver gating FSM; en low overrides every other transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_OFF;
            rx_rst <= 1'b1;
            rc_cnt <= 1'b0;
        end else if (!en) begin
            state  <= S_OFF;
            rx_rst <= 1'b1;
            rc_cnt <= 1'b0;
        end else begin
            case (state)
                S_OFF, S_RUN: begin
                    if (reconf_go_c) begin
                        state  <= S_RECONF;
                        rx_rst <= 1'b1;
                        rc_cnt <= 1'b0;
                    end else if (state == S_OFF) begin
                        state  <= S_RUN;
                        rx_rst <= 1'b0;
                    end
                end
                S_RECONF: begin
                    if (rc_cnt) begin
                        state  <= S_RUN;
                        rx_rst <= 1'b0;
                        rc_cnt <= 1'b0;
                    end else begin
                        rc_cnt <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_OFF;
                    rx_rst <= 1'b1;
                    rc_cnt <= 1'b0;
                end
            endcase
        end
    end

    // Pending configuration; a write coinciding with application stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_parity <= 2'd0;
            pend_stop   <= 2'd0;
            pend_div    <= DIV_RST;
            cfg_pending <= 1'b0;
        end else if (cfg_wr) begin
            pend_parity <= cfg_parity_in;
            pend_stop   <= cfg_stop_bits_in;
            pend_div    <= cfg_clk_div_in;
            cfg_pending <= 1'b1;
        end else if (reconf_go_c) begin
            cfg_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_parity    <= 2'd0;
            cfg_stop_bits <= 2'd0;
            cfg_clk_div   <= DIV_RST;
        end else if (reconf_go_c) begin
            cfg_parity    <= pend_parity;
            cfg_stop_bits <= pend_stop;
            cfg_clk_div   <= pend_div;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c)
            mem[wr_ptr] <= {parity_err, rx_dout};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            m_valid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_c)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + AW'(1);
            level   <= level_nxt_c;
            m_valid <= (level_nxt_c != '0);
            if (drop_c)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // Idle counter saturates at cfg_timeout so each idle period pulses once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= 16'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (idle_clr_c) begin
                idle_cnt <= 16'd0;
            end else if (idle_cnt < cfg_timeout) begin
                idle_cnt <= idle_cnt + 16'd1;
                timeout  <= ((idle_cnt + 16'd1) == cfg_timeout);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus queues expected FIFO entries,
// a negedge monitor compares every popped head against the queue.
module tb_uart_rx_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              en;
    logic              cfg_wr;
    logic [1:0]        cfg_parity_in;
    logic [1:0]        cfg_stop_bits_in;
    logic [15:0]       cfg_clk_div_in;
    logic [15:0]       cfg_timeout;
    logic              uart_rx;
    logic [WIDTH-1:0]  rx_dout;
    logic              rx_valid;
    logic              parity_err;
    logic              rx_rst;
    logic [1:0]        cfg_parity;
    logic [1:0]        cfg_stop_bits;
    logic [15:0]       cfg_clk_div;
    logic [WIDTH-1:0]  m_data;
    logic              m_perr;
    logic              m_valid;
    logic              m_ready;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              ovf_clr;
    logic              cfg_pending;
    logic              timeout;

    int                checks = 0;
    int                errors = 0;
    logic [WIDTH:0]    sb [$];
    logic [WIDTH:0]    exp_e;

    uart_rx_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .cfg_wr           (cfg_wr),
        .cfg_parity_in    (cfg_parity_in),
        .cfg_stop_bits_in (cfg_stop_bits_in),
        .cfg_clk_div_in   (cfg_clk_div_in),
        .cfg_timeout      (cfg_timeout),
        .uart_rx          (uart_rx),
        .rx_dout          (rx_dout),
        .rx_valid         (rx_valid),
        .parity_err       (parity_err),
        .rx_rst           (rx_rst),
        .cfg_parity       (cfg_parity),
        .cfg_stop_bits    (cfg_stop_bits),
        .cfg_clk_div      (cfg_clk_div),
        .m_data           (m_data),
        .m_perr           (m_perr),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .level            (level),
        .overflow         (overflow),
        .ovf_clr          (ovf_clr),
        .cfg_pending      (cfg_pending),
        .timeout          (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic pe, input logic accept);
        rx_valid   = 1'b1;
        rx_dout    = d;
        parity_err = pe;
        if (accept)
            sb.push_back({pe, d});
        tick();
        rx_valid   = 1'b0;
        parity_err = 1'b0;
    endtask

    task automatic pop_n(input int n);
        m_ready = 1'b1;
        repeat (n) tick();
        m_ready = 1'b0;
    endtask

    // Monitor: every accepted pop must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got 0x%0h expected no entry", {m_perr, m_data});
            end else begin
                exp_e = sb.pop_front();
                chk("fifo_head", 32'({m_perr, m_data}), 32'(exp_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses;
        rst = 1'b1; en = 1'b0; cfg_wr = 1'b0;
        cfg_parity_in = 2'd0; cfg_stop_bits_in = 2'd0; cfg_clk_div_in = 16'd0;
        cfg_timeout = 16'd0; uart_rx = 1'b1; rx_dout = '0; rx_valid = 1'b0;
        parity_err = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();

        chk("rst_rx_rst", 32'(rx_rst), 32'd1);
        chk("rst_cfg_parity", 32'(cfg_parity), 32'd0);
        chk("rst_cfg_stop", 32'(cfg_stop_bits), 32'd0);
        chk("rst_cfg_div", 32'(cfg_clk_div), 32'd53);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        rst = 1'b0;
        repeat (2) tick();
        chk("off_hold_rx_rst", 32'(rx_rst), 32'd1);
        en = 1'b1;
        tick();
        chk("run_rx_rst", 32'(rx_rst), 32'd0);

        // Single character round trip
        push_byte(8'hA5, 1'b0, 1'b1);
        chk("a5_m_valid", 32'(m_valid), 32'd1);
        chk("a5_m_data", 32'(m_data), 32'hA5);
        chk("a5_level", 32'(level), 32'd1);
        pop_n(1);
        chk("a5_level_after_pop", 32'(level), 32'd0);

        // Nine pushes into an eight-entry FIFO
        for (int i = 0; i < 9; i++)
            push_byte(8'(8'h10 + i), i[0], (i < 8) ? 1'b1 : 1'b0);
        chk("full_level", 32'(level), 32'd8);
        chk("full_overflow", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push and pop together while full
        m_ready = 1'b1;
        push_byte(8'h77, 1'b0, 1'b1);
        m_ready = 1'b0;
        chk("full_pp_level", 32'(level), 32'd8);
        chk("full_pp_overflow", 32'(overflow), 32'd0);
        pop_n(8);
        chk("drained_level", 32'(level), 32'd0);
        chk("drained_m_valid", 32'(m_valid), 32'd0);

        // Drop coinciding with ovf_clr keeps overflow set
        for (int i = 0; i < 8; i++)
            push_byte(8'(8'hC0 + i), 1'b0, 1'b1);
        ovf_clr = 1'b1;
        push_byte(8'hFF, 1'b0, 1'b0);
        chk("drop_with_clr", 32'(overflow), 32'd1);
        tick();
        ovf_clr = 1'b0;
        chk("clr_after_drop", 32'(overflow), 32'd0);
        pop_n(8);

        pop_n(2);
        chk("empty_pop_level", 32'(level), 32'd0);
        chk("empty_pop_m_valid", 32'(m_valid), 32'd0);

        // Configuration deferred while the line is busy
        uart_rx = 1'b0;
        repeat (3) tick();
        cfg_wr = 1'b1; cfg_clk_div_in = 16'h001A; cfg_parity_in = 2'd2; cfg_stop_bits_in = 2'd1;
        tick();
        cfg_wr = 1'b0;
        repeat (3) tick();
        chk("busy_pending", 32'(cfg_pending), 32'd1);
        chk("busy_div", 32'(cfg_clk_div), 32'd53);
        chk("busy_parity", 32'(cfg_parity), 32'd0);
        chk("busy_rx_rst", 32'(rx_rst), 32'd0);

        uart_rx = 1'b1;
        n = 0;
        while (rx_rst !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("reconf_latency", 32'(n), 32'd3);
        chk("reconf_div", 32'(cfg_clk_div), 32'h001A);
        chk("reconf_parity", 32'(cfg_parity), 32'd2);
        chk("reconf_stop", 32'(cfg_stop_bits), 32'd1);
        chk("reconf_pending", 32'(cfg_pending), 32'd0);
        push_byte(8'hEE, 1'b0, 1'b0);
        chk("reconf_rx_rst_2nd", 32'(rx_rst), 32'd1);
        chk("reconf_push_ignored", 32'(level), 32'd0);
        tick();
        chk("reconf_done_rx_rst", 32'(rx_rst), 32'd0);
        chk("reconf_no_ovf", 32'(overflow), 32'd0);

        // Idle timeout
        cfg_timeout = 16'd100;
        push_byte(8'h3C, 1'b1, 1'b1);
        n = 0;
        while (timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_delay", 32'(n), 32'd100);
        pulses = 0;
        repeat (150) begin
            tick();
            if (timeout === 1'b1)
                pulses++;
        end
        chk("timeout_single", 32'(pulses), 32'd0);
        pop_n(1);
        cfg_timeout = 16'd0;

        // Disable with data held, then reset mid-drain
        push_byte(8'h01, 1'b0, 1'b1);
        push_byte(8'h82, 1'b1, 1'b1);
        push_byte(8'h43, 1'b0, 1'b1);
        en = 1'b0;
        tick();
        chk("off_rx_rst", 32'(rx_rst), 32'd1);
        push_byte(8'h99, 1'b0, 1'b0);
        chk("off_level", 32'(level), 32'd3);
        pop_n(2);
        chk("off_drain_level", 32'(level), 32'd1);
        chk("sb_remaining", 32'(sb.size()), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_div", 32'(cfg_clk_div), 32'd53);
        sb.delete();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
